// File: rtl/ts_pkg.sv
// Shared transport-stream definitions for the TS transmit, receive and monitor blocks.
package ts_pkg;

    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
    localparam int unsigned TS_PKT_LEN   = 188;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } ts_sync_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; read data is the head entry (show-ahead).
module sync_fifo #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    output logic [W-1:0]  rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_wr, do_rd;

    assign full_o    = count_q[AW];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ts_parallel_tx.sv
// Parallel TS transmitter: byte FIFO, DCLK generator and 188-byte packet sync FSM
// driving DATA/DCLK/D_VALID toward a tuner-style receiver.
module ts_parallel_tx
    import ts_pkg::*;
#(
    parameter int DIV     = 2,
    parameter int FIFO_AW = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] IN_DATA,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic [7:0] DATA_OUT,
    output logic       DCLK_OUT,
    output logic       D_VALID_OUT,
    output logic       SYNC_ERR,
    output logic       UNDERRUN
);
    localparam int                PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]     PH_LAST  = PW'(DIV - 1);
    localparam logic [FIFO_AW:0]  ALMOST   = (FIFO_AW + 1)'((1 << FIFO_AW) - 1);
    localparam logic [7:0]        POS_LAST = 8'(TS_PKT_LEN - 1);

    logic [PW-1:0]    phase_q, phase_d;
    logic             dclk_q, dclk_d;
    ts_sync_state_e   state_q, state_d;
    logic [7:0]       pos_q, pos_d;
    logic [7:0]       data_q, data_d;
    logic             dvalid_q, dvalid_d;
    logic             sync_err_q, sync_err_d;
    logic             underrun_q, underrun_d;
    logic             in_ready_q, in_ready_d;

    logic             phase_end;
    logic             load;
    logic             wr_fire;
    logic             rd_en;
    logic [7:0]       fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;

    assign IN_READY    = in_ready_q;
    assign DATA_OUT    = data_q;
    assign DCLK_OUT    = dclk_q;
    assign D_VALID_OUT = dvalid_q;
    assign SYNC_ERR    = sync_err_q;
    assign UNDERRUN    = underrun_q;

    assign wr_fire = IN_VALID && in_ready_q;

    sync_fifo #(
        .AW (FIFO_AW),
        .W  (8)
    ) u_fifo (
        .clk_i     (CLK),
        .rst_i     (RST),
        .wr_en_i   (wr_fire),
        .wr_data_i (IN_DATA),
        .rd_en_i   (rd_en),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // The load instant is the cycle that drives DCLK 1->0, so new data settles a
    // full half-period ahead of the receiver's rising-edge sample.
    assign phase_end = (phase_q == PH_LAST);
    assign load      = phase_end && dclk_q;

    always_comb begin
        phase_d = phase_end ? '0 : phase_q + 1'b1;
        dclk_d  = phase_end ? !dclk_q : dclk_q;
    end

    // IN_READY reflects the occupancy that will hold after this edge.
    always_comb begin
        if (fifo_full) begin
            in_ready_d = rd_en;
        end else begin
            in_ready_d = !((fifo_count == ALMOST) && wr_fire && !rd_en);
        end
    end

    // state  | meaning
    // HUNT   | searching for 0x47; popped bytes are discarded
    // LOCKED | inside packet stream; pos = index of next byte, 0 expects sync
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        data_d     = data_q;
        dvalid_d   = dvalid_q;
        sync_err_d = 1'b0;
        underrun_d = 1'b0;
        rd_en      = 1'b0;
        if (load) begin
            dvalid_d = 1'b0;
            if (fifo_empty) begin
                if ((state_q == LOCKED) && (pos_q != '0)) begin
                    underrun_d = 1'b1;
                end
            end else begin
                rd_en  = 1'b1;
                data_d = fifo_rd_data;
                case (state_q)
                    HUNT: begin
                        if (fifo_rd_data == TS_SYNC_BYTE) begin
                            dvalid_d = 1'b1;
                            pos_d    = 8'd1;
                            state_d  = LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (pos_q != '0) begin
                            dvalid_d = 1'b1;
                            pos_d    = (pos_q == POS_LAST) ? 8'd0 : pos_q + 8'd1;
                        end else if (fifo_rd_data == TS_SYNC_BYTE) begin
                            dvalid_d = 1'b1;
                            pos_d    = 8'd1;
                        end else begin
                            sync_err_d = 1'b1;
                            state_d    = HUNT;
                        end
                    end
                    default: begin
                        state_d = HUNT;
                        pos_d   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_q    <= '0;
            dclk_q     <= 1'b0;
            state_q    <= HUNT;
            pos_q      <= '0;
            data_q     <= '0;
            dvalid_q   <= 1'b0;
            sync_err_q <= 1'b0;
            underrun_q <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            dclk_q     <= dclk_d;
            state_q    <= state_d;
            pos_q      <= pos_d;
            data_q     <= data_d;
            dvalid_q   <= dvalid_d;
            sync_err_q <= sync_err_d;
            underrun_q <= underrun_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_ts_parallel_tx.sv
// Scoreboard bench for ts_parallel_tx: accepted bytes are queued with their expected
// packet outcome; a negedge monitor pops them at each modelled DCLK fall and compares.
module tb_ts_parallel_tx;
    localparam int DIV     = 2;
    localparam int FIFO_AW = 4;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int PKT     = 188;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] IN_DATA = 8'h00;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [7:0] DATA_OUT;
    logic       DCLK_OUT;
    logic       D_VALID_OUT;
    logic       SYNC_ERR;
    logic       UNDERRUN;

    int errors = 0;
    int checks = 0;

    ts_parallel_tx #(.DIV(DIV), .FIFO_AW(FIFO_AW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IN_DATA     (IN_DATA),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .DATA_OUT    (DATA_OUT),
        .DCLK_OUT    (DCLK_OUT),
        .D_VALID_OUT (D_VALID_OUT),
        .SYNC_ERR    (SYNC_ERR),
        .UNDERRUN    (UNDERRUN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        bit         valid;
        bit         serr;
        bit         mid;
        int         wcyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Packet-level reference state: in_pkt/next_idx track where the next accepted byte falls.
    bit         in_pkt;
    int         next_idx;
    bit         mid;
    int         n;
    bit         started = 1'b0;
    bit         rst_pend = 1'b0;
    bit         wr_pend = 1'b0;
    logic [7:0] wr_byte;
    logic [7:0] exp_data;
    bit         exp_valid, exp_serr, exp_urun, exp_rdy, exp_dclk;
    exp_t       e;

    always @(negedge CLK) begin
        if (rst_pend) begin
            started   = 1'b1;
            n         = 0;
            sb.delete();
            in_pkt    = 1'b0;
            next_idx  = 0;
            mid       = 1'b0;
            exp_data  = 8'h00;
            exp_valid = 1'b0;
            exp_serr  = 1'b0;
            exp_urun  = 1'b0;
            exp_rdy   = 1'b0;
        end else if (started) begin
            n++;
            exp_serr = 1'b0;
            exp_urun = 1'b0;
            if (wr_pend) begin
                e.data  = wr_byte;
                e.valid = 1'b0;
                e.serr  = 1'b0;
                e.wcyc  = n;
                if (!in_pkt) begin
                    if (wr_byte == 8'h47) begin
                        e.valid  = 1'b1;
                        in_pkt   = 1'b1;
                        next_idx = 1;
                    end
                end else if (next_idx != 0) begin
                    e.valid  = 1'b1;
                    next_idx = (next_idx + 1) % PKT;
                end else if (wr_byte == 8'h47) begin
                    e.valid  = 1'b1;
                    next_idx = 1;
                end else begin
                    e.serr = 1'b1;
                    in_pkt = 1'b0;
                end
                e.mid = in_pkt && (next_idx != 0);
                sb.push_back(e);
            end
            if (n % (2 * DIV) == 0) begin
                if (sb.size() > 0 && sb[0].wcyc < n) begin
                    e         = sb.pop_front();
                    exp_data  = e.data;
                    exp_valid = e.valid;
                    exp_serr  = e.serr;
                    mid       = e.mid;
                end else begin
                    exp_valid = 1'b0;
                    exp_urun  = mid;
                end
            end
            exp_rdy = (sb.size() < DEPTH);
        end
        if (started) begin
            exp_dclk = ((n / DIV) % 2) == 1;
            check("dclk",     32'(DCLK_OUT),    32'(exp_dclk));
            check("data",     32'(DATA_OUT),    32'(exp_data));
            check("d_valid",  32'(D_VALID_OUT), 32'(exp_valid));
            check("sync_err", 32'(SYNC_ERR),    32'(exp_serr));
            check("underrun", 32'(UNDERRUN),    32'(exp_urun));
            check("in_ready", 32'(IN_READY),    32'(exp_rdy));
        end
        rst_pend = (RST === 1'b1);
        wr_pend  = started && !rst_pend && (IN_VALID === 1'b1) && (IN_READY === 1'b1);
        wr_byte  = IN_DATA;
    end

    task automatic send_byte(input logic [7:0] b);
        bit rdy;
        bit done;
        done     = 1'b0;
        IN_DATA  = b;
        IN_VALID = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            rdy = (IN_READY === 1'b1);
            @(posedge CLK);
            #1;
            done = rdy;
        end
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: byte %0h never accepted", b);
        end
        IN_VALID = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_packet(input logic [7:0] first, input bit counting, input int max_gap);
        logic [7:0] b;
        for (int i = 0; i < PKT; i++) begin
            if (i == 0)         b = first;
            else if (counting)  b = 8'(i);
            else                b = 8'($urandom_range(0, 255));
            send_byte(b);
            if (max_gap > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, max_gap));
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 3000) begin
            idle(1);
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d bytes still queued, required 0", sb.size());
        end
        idle(4 * DIV);
    endtask

    task automatic pulse_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        RST      = 1'b1;
        IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Basic counting packet plus a second random one (continuous, exercises backpressure).
        send_packet(8'h47, 1'b1, 0);
        send_packet(8'h47, 1'b0, 0);
        drain();

        // Hunt from reset: two junk bytes, then a packet.
        pulse_reset();
        send_byte(8'h12);
        send_byte(8'h34);
        send_packet(8'h47, 1'b0, 0);

        // Sync loss: a non-sync byte where the next packet should start, then relock.
        send_byte(8'h00);
        send_packet(8'h47, 1'b0, 0);
        drain();

        // Underrun: stall after byte 100 until drained plus three DCLK periods.
        for (int i = 0; i <= 100; i++) send_byte(i == 0 ? 8'h47 : 8'($urandom_range(0, 255)));
        drain();
        idle(3 * 2 * DIV);
        for (int i = 101; i < PKT; i++) send_byte(8'($urandom_range(0, 255)));
        send_packet(8'h47, 1'b0, 0);

        // Randomly gapped input.
        send_packet(8'h47, 1'b0, 10);
        send_packet(8'h47, 1'b0, 6);
        drain();

        // Reset in the middle of a packet, then a fresh packet.
        send_byte(8'h47);
        for (int i = 1; i < 50; i++) send_byte(8'($urandom_range(0, 255)));
        pulse_reset();
        send_packet(8'h47, 1'b1, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
